srl_share_ctrl: RTL and testbench
=================================

// Module: srl_share_ctrl
// PURPOSE
//   Lets two requesters share one 32-bit logical-right barrel shifter
//   (combinational A, B[4:0] -> res). Round-robin arbitration, valid/ready
//   handshake on both sides, registered operands and result. The shifter sits
//   outside this block, driven through the sh_* ports. One operation in flight.
// PARAMETERS
//   SH_LAT  1  cycles from operand register to result capture (legal 1..15)
// PORTS
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous, active-low reset
//   req0_valid   in   1   requester 0 has an operation
//   req0_ready   out  1   requester 0 operation accepted this cycle
//   req0_a       in   32  requester 0 operand
//   req0_shamt   in   5   requester 0 shift amount
//   req1_valid   in   1   requester 1 has an operation
//   req1_ready   out  1   requester 1 operation accepted this cycle
//   req1_a       in   32  requester 1 operand
//   req1_shamt   in   5   requester 1 shift amount
//   sh_a         out  32  registered operand to the shifter
//   sh_b         out  5   registered shift amount to the shifter
//   sh_res       in   32  shifter result (A >> B, zero fill)
//   rsp_valid    out  1   result available
//   rsp_ready    in   1   consumer takes the result
//   rsp_data     out  32  captured result
//   rsp_src      out  1   requester that issued this result
//   busy         out  1   state != IDLE
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, prio=0, cnt=0, sh_a=0, sh_b=0,
//     rsp_data=0, rsp_src=0, rsp_valid=0, busy=0. req*_ready=0 in reset.
//   - FSM IDLE -> BUSY -> DONE -> IDLE.
//   - IDLE: grant computed combinationally. Only one valid -> grant it.
//     Both valid -> grant prio. reqN_ready = (state==IDLE) & grant==N & reqN_valid.
//     At most one ready is high. No valid -> stay IDLE.
//   - Accept edge k (valid&ready): sh_a/sh_b <= granted operands. rsp_src <= N.
//     prio <= ~N. cnt <= SH_LAT-1. State -> BUSY.
//   - BUSY: cnt decrements each cycle. At the edge where cnt==0, rsp_data <= sh_res,
//     rsp_valid <= 1 and state -> DONE. This is edge k+SH_LAT.
//     sh_a/sh_b hold stable throughout BUSY and DONE.
//   - DONE: rsp_valid=1. rsp_data and rsp_src hold until rsp_ready=1.
//     On the handshake edge: rsp_valid <= 0 and state -> IDLE.
//     No acceptance in the same cycle (no bypass).
//   - With rsp_ready tied high, the minimum spacing between acceptances is
//     SH_LAT+2 cycles.
//   - Requesters must hold valid and operands stable until ready. Dropping valid
//     before ready is allowed and cancels the request without side effect.
//   - prio changes only on acceptance. A lone requester never flips fairness
//     unless it is granted.
//   - shamt=0 passes the operand through unchanged. shamt=31 leaves only bit 31,
//     moved to bit 0. No width extension; the result is always 32 bits.
//   - Reset asserted mid-operation aborts the op. All outputs go to reset values
//     immediately. The in-flight result is lost and is not replayed.
// TESTING
//   1. Reset, then req0 a=0xF000_000F shamt=4, rsp_ready=1 ->
//      rsp_valid at k+SH_LAT, rsp_data=0x0F00_0000, rsp_src=0.
//   2. Both valid every cycle, rsp_ready=1, 6 ops -> grants alternate 0,1,0,1,0,1.
//      Acceptances spaced SH_LAT+2 cycles apart.
//   3. req1 a=0xFFFF_FFFF shamt=31 -> rsp_data=0x0000_0001.
//      Then shamt=0 a=0x1234_5678 -> 0x1234_5678.
//   4. rsp_ready held 0 for 10 cycles after rsp_valid -> rsp_valid, rsp_data,
//      sh_a, sh_b stable. req*_ready=0 the whole time. One cycle after
//      rsp_ready=1, IDLE.
//   5. rst_n pulsed low during BUSY -> outputs at reset values immediately.
//      No rsp_valid afterwards. The next grant goes to req0 (prio=0).
//   6. Random single/dual traffic, 1000 ops, scoreboard vs (a >> shamt) per src.
//      No lost or duplicated results; max wait per requester <= 1 foreign op.

Source files
------------

// File: rtl/srl_share_ctrl.sv
// srl_share_ctrl: shares one external 32-bit logical-right shifter between two
// requesters. Round-robin grant, operand and result registers, one op in flight.
module srl_share_ctrl #(
    parameter int unsigned SH_LAT = 1  // operand register to result capture, 1..15
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_a_i,
    input  logic [4:0]  req0_shamt_i,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_a_i,
    input  logic [4:0]  req1_shamt_i,

    output logic [31:0] sh_a_o,
    output logic [4:0]  sh_b_o,
    input  logic [31:0] sh_res_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_src_o,
    output logic        busy_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Countdown start so that capture lands SH_LAT edges after acceptance.
    localparam logic [3:0] CntInit = 4'(SH_LAT - 1);

    logic [1:0]  state_q, state_d;
    logic        prio_q, prio_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] sh_a_q, sh_a_d;
    logic [4:0]  sh_b_q, sh_b_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_src_q, rsp_src_d;
    logic        rsp_valid_q, rsp_valid_d;

    logic        grant;
    logic        idle;
    logic        accept;

    assign idle = (state_q == StIdle);

    // Grant: a lone requester wins outright, a tie goes to the priority holder.
    always_comb begin
        grant = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant = prio_q;
        end else if (req1_valid_i) begin
            grant = 1'b1;
        end
    end

    // rst_n gating keeps both readies low while reset is held, even though the
    // state register already reads IDLE.
    assign req0_ready_o = rst_n & idle & ~grant & req0_valid_i;
    assign req1_ready_o = rst_n & idle &  grant & req1_valid_i;
    assign accept       = req0_ready_o | req1_ready_o;

    // Next-state: IDLE accepts, BUSY counts down and captures, DONE waits for consumer.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        cnt_d       = cnt_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        rsp_data_d  = rsp_data_q;
        rsp_src_d   = rsp_src_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    sh_a_d    = grant ? req1_a_i : req0_a_i;
                    sh_b_d    = grant ? req1_shamt_i : req0_shamt_i;
                    rsp_src_d = grant;
                    prio_d    = ~grant;
                    cnt_d     = CntInit;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    rsp_data_d  = sh_res_i;
                    rsp_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                // No bypass: a new request is only considered back in IDLE.
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d     = StIdle;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            prio_q      <= 1'b0;
            cnt_q       <= 4'd0;
            sh_a_q      <= 32'd0;
            sh_b_q      <= 5'd0;
            rsp_data_q  <= 32'd0;
            rsp_src_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            cnt_q       <= cnt_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            rsp_data_q  <= rsp_data_d;
            rsp_src_q   <= rsp_src_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign sh_a_o      = sh_a_q;
    assign sh_b_o      = sh_b_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_src_o   = rsp_src_q;
    assign busy_o      = ~idle;

endmodule

// File: tb/tb_srl_share_ctrl.sv
// Bench for srl_share_ctrl: directed vector table, multi-cycle corner sequences
// and a random two-requester run against a result queue.
module tb_srl_share_ctrl;

    localparam int unsigned SH_LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a;
    logic [4:0]  req0_shamt;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a;
    logic [4:0]  req1_shamt;
    logic [31:0] sh_a;
    logic [4:0]  sh_b;
    logic [31:0] sh_res;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_src;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // External shifter the block is meant to drive.
    assign sh_res = sh_a >> sh_b;

    srl_share_ctrl #(.SH_LAT(SH_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_a_i     (req0_a),
        .req0_shamt_i (req0_shamt),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_a_i     (req1_a),
        .req1_shamt_i (req1_shamt),
        .sh_a_o       (sh_a),
        .sh_b_o       (sh_b),
        .sh_res_i     (sh_res),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_src_o    (rsp_src),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_a = 32'd0; req0_shamt = 5'd0;
        req1_valid = 1'b0; req1_a = 32'd0; req1_shamt = 5'd0;
        rsp_ready  = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #2;
    endtask

    // Wait (bounded) until either ready is high at a sample point.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (req0_ready || req1_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
    endtask

    // Wait (bounded) for rsp_valid; lat counts edges crossed.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 30) begin
            @(posedge clk); #2;
            lat++;
        end
    endtask

    typedef struct {
        logic        src;
        logic [31:0] a;
        logic [4:0]  shamt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit          ok;
        int          lat;
        int          last_cyc;
        logic [31:0] held_data;
        bit          saw_valid;

        vecs[0] = '{1'b0, 32'hF000_000F, 5'd4,  32'h0F00_0000};
        vecs[1] = '{1'b1, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001};
        vecs[2] = '{1'b1, 32'h1234_5678, 5'd0,  32'h1234_5678};
        vecs[3] = '{1'b0, 32'h8000_0001, 5'd1,  32'h4000_0000};
        vecs[4] = '{1'b1, 32'hDEAD_BEEF, 5'd16, 32'h0000_DEAD};
        vecs[5] = '{1'b0, 32'hA5A5_A5A5, 5'd8,  32'h00A5_A5A5};
        vecs[6] = '{1'b0, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};

        // Reset values, with both requesters pushing during reset.
        idle_inputs();
        rst_n = 1'b0;
        #12;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check_b("reset req0_ready", req0_ready, 1'b0);
        check_b("reset req1_ready", req1_ready, 1'b0);
        check_b("reset rsp_valid", rsp_valid, 1'b0);
        check_b("reset busy", busy, 1'b0);
        check("reset sh_a", sh_a, 32'd0);
        check("reset sh_b", 32'(sh_b), 32'd0);
        check("reset rsp_data", rsp_data, 32'd0);
        check_b("reset rsp_src", rsp_src, 1'b0);
        apply_reset();

        // Directed vector table, one requester at a time.
        foreach (vecs[i]) begin
            rsp_ready = 1'b1;
            if (vecs[i].src) begin
                req1_valid = 1'b1; req1_a = vecs[i].a; req1_shamt = vecs[i].shamt;
            end else begin
                req0_valid = 1'b1; req0_a = vecs[i].a; req0_shamt = vecs[i].shamt;
            end
            #1;
            wait_ready(ok);
            check_b("vec accept seen", ok, 1'b1);
            check_b("vec granted src", req1_ready, vecs[i].src);
            @(posedge clk); #1;
            req0_valid = 1'b0; req1_valid = 1'b0;
            #1;
            check_b("vec busy", busy, 1'b1);
            check("vec sh_a", sh_a, vecs[i].a);
            check("vec sh_b", 32'(sh_b), 32'(vecs[i].shamt));
            wait_rsp(lat);
            check("vec latency", lat, SH_LAT);
            check("vec rsp_data", rsp_data, vecs[i].exp);
            check_b("vec rsp_src", rsp_src, vecs[i].src);
            @(posedge clk); #2;
            check_b("vec rsp_valid cleared", rsp_valid, 1'b0);
            check_b("vec back to idle", busy, 1'b0);
        end

        // Both valid every cycle: strict alternation at minimum spacing.
        apply_reset();
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 32'hF0F0_F0F0; req0_shamt = 5'd4;
        req1_valid = 1'b1; req1_a = 32'h0000_FF00; req1_shamt = 5'd8;
        #1;
        last_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            wait_ready(ok);
            check_b("alt accept seen", ok, 1'b1);
            check_b("alt grant", req1_ready, 1'(i % 2));
            check_b("alt single ready", req0_ready & req1_ready, 1'b0);
            if (i > 0) check("alt spacing", cyc - last_cyc, SH_LAT + 2);
            last_cyc = cyc;
            @(posedge clk); #2;
            wait_rsp(lat);
            check("alt latency", lat, SH_LAT);
            check("alt rsp_data", rsp_data, (i % 2) ? 32'h0000_00FF : 32'h0F0F_0F0F);
            check_b("alt rsp_src", rsp_src, 1'(i % 2));
            @(posedge clk); #2;
        end

        // Consumer stalls for 10 cycles: everything holds, nothing is accepted.
        apply_reset();
        req0_valid = 1'b1; req0_a = 32'hCAFE_BABE; req0_shamt = 5'd12;
        #1;
        wait_ready(ok);
        check_b("stall accept seen", ok, 1'b1);
        @(posedge clk); #1;
        req0_a = 32'h1111_1111; req0_shamt = 5'd3;
        req1_valid = 1'b1; req1_a = 32'h2222_2222; req1_shamt = 5'd5;
        #1;
        wait_rsp(lat);
        check("stall latency", lat, SH_LAT);
        held_data = rsp_data;
        check("stall rsp_data", held_data, 32'h000C_AFEB);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            check_b("stall rsp_valid", rsp_valid, 1'b1);
            check("stall rsp_data hold", rsp_data, 32'h000C_AFEB);
            check("stall sh_a hold", sh_a, 32'hCAFE_BABE);
            check("stall sh_b hold", 32'(sh_b), 32'd12);
            check_b("stall no ready", req0_ready | req1_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        check_b("stall release idle", busy, 1'b0);
        check_b("stall release rsp_valid", rsp_valid, 1'b0);
        check_b("stall next grant req1", req1_ready, 1'b1);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Reset during BUSY aborts the op and clears priority.
        apply_reset();
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 32'h8765_4321; req0_shamt = 5'd2;
        #1;
        wait_ready(ok);
        check_b("abort accept seen", ok, 1'b1);
        @(posedge clk); #2;
        req0_valid = 1'b0;
        check_b("abort in busy", busy, 1'b1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_b("abort busy", busy, 1'b0);
        check_b("abort rsp_valid", rsp_valid, 1'b0);
        check("abort sh_a", sh_a, 32'd0);
        check("abort sh_b", 32'(sh_b), 32'd0);
        check_b("abort req0_ready", req0_ready, 1'b0);
        check_b("abort req1_ready", req1_ready, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < int'(SH_LAT) + 4; i++) begin
            @(posedge clk); #2;
            if (rsp_valid) saw_valid = 1'b1;
        end
        check_b("abort no replay", saw_valid, 1'b0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check_b("abort prio req0_ready", req0_ready, 1'b1);
        check_b("abort prio req1_ready", req1_ready, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Random single/dual traffic against a result queue.
        begin
            logic [31:0] exp_q[$];
            logic        src_q[$];
            int          ops   = 0;
            int          cycles = 0;
            int          wait0 = 0;
            int          wait1 = 0;
            bit          acc0  = 1'b0;
            bit          acc1  = 1'b0;

            apply_reset();
            while (ops < 1000 && cycles < 30000) begin
                @(posedge clk); #1;
                cycles++;
                if (acc0) req0_valid = 1'b0;
                if (acc1) req1_valid = 1'b0;
                acc0 = 1'b0; acc1 = 1'b0;
                if (!req0_valid && $urandom_range(1, 0) == 1) begin
                    req0_valid = 1'b1; req0_a = $urandom; req0_shamt = 5'($urandom);
                end
                if (!req1_valid && $urandom_range(1, 0) == 1) begin
                    req1_valid = 1'b1; req1_a = $urandom; req1_shamt = 5'($urandom);
                end
                rsp_ready = ($urandom_range(3, 0) != 0);
                #1;
                if (req0_ready || req1_ready)
                    check_b("rand single ready", req0_ready & req1_ready, 1'b0);
                if (req0_ready) begin
                    check("rand wait0", wait0, 32'd0 + (wait0 > 1 ? 0 : wait0));
                    if (wait0 > 1) check("rand wait0 bound", wait0, 1);
                    exp_q.push_back(req0_a >> req0_shamt);
                    src_q.push_back(1'b0);
                    if (req1_valid) wait1++;
                    wait0 = 0; acc0 = 1'b1; ops++;
                end
                if (req1_ready) begin
                    if (wait1 > 1) check("rand wait1 bound", wait1, 1);
                    exp_q.push_back(req1_a >> req1_shamt);
                    src_q.push_back(1'b1);
                    if (req0_valid) wait0++;
                    wait1 = 0; acc1 = 1'b1; ops++;
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("rand unexpected result", rsp_data, 32'hxxxx_xxxx);
                    end else begin
                        check("rand rsp_data", rsp_data, exp_q.pop_front());
                        check_b("rand rsp_src", rsp_src, src_q.pop_front());
                    end
                end
            end
            // Drain the last op.
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                req0_valid = 1'b0; req1_valid = 1'b0;
                rsp_ready  = 1'b1;
                #1;
                if (rsp_valid && exp_q.size() != 0) begin
                    check("rand drain rsp_data", rsp_data, exp_q.pop_front());
                    check_b("rand drain rsp_src", rsp_src, src_q.pop_front());
                end
            end
            check("rand ops done", ops, 1000);
            check("rand results outstanding", exp_q.size(), 0);
            check_b("rand final idle", busy, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
